// File: rtl/mdu_pipe.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// Define MDU_MADD_EN to add MADD/MSUB (signed multiply-accumulate into {hi,lo}).
module mdu_pipe #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_MADD  = 3'd6,
        OP_MSUB  = 3'd7
    } op_e;

    logic             r_busy;
    logic             r_done;
    logic [3:0]       r_cnt;
    op_e              r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic               w_accept;
    logic               w_long;
    logic [3:0]         w_load;
    logic               w_signed;
    logic [2*WIDTH-1:0] w_ax;
    logic [2*WIDTH-1:0] w_bx;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_div_ovf;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    assign w_accept = start && !r_busy && !flush;

    // NOTE: every variable written in an always_comb gets a default first, so no path infers a latch.
    always_comb begin
        w_long = 1'b0;
        w_load = 4'(MULT_CYCLES);
        case (op_e'(op))
            OP_MULT, OP_MULTU: w_long = 1'b1;
            OP_DIV, OP_DIVU: begin
                w_long = 1'b1;
                w_load = 4'(DIV_CYCLES);
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MSUB: w_long = 1'b1;
`endif
            default: w_long = 1'b0;
        endcase
    end

    // Low 2*WIDTH bits of the product of extended operands give both signed and unsigned results.
    assign w_signed  = (r_op != OP_MULTU);
    assign w_ax      = {{WIDTH{r_a[WIDTH-1] & w_signed}}, r_a};
    assign w_bx      = {{WIDTH{r_b[WIDTH-1] & w_signed}}, r_b};
    assign w_prod    = w_ax * w_bx;
    assign w_div_ovf = (r_a == {1'b1, {(WIDTH-1){1'b0}}}) && (r_b == {WIDTH{1'b1}});

    always_comb begin
        w_res_hi = r_hi;
        w_res_lo = r_lo;
        case (r_op)
            OP_MULT, OP_MULTU: {w_res_hi, w_res_lo} = w_prod;
            OP_DIV: begin
                if (r_b == '0) begin
                    w_res_hi = r_hi;
                end else if (w_div_ovf) begin
                    w_res_hi = '0;
                    w_res_lo = r_a;
                end else begin
                    w_res_lo = $signed(r_a) / $signed(r_b);
                    w_res_hi = $signed(r_a) % $signed(r_b);
                end
            end
            OP_DIVU: begin
                if (r_b != '0) begin
                    w_res_lo = r_a / r_b;
                    w_res_hi = r_a % r_b;
                end
            end
`ifdef MDU_MADD_EN
            OP_MADD: {w_res_hi, w_res_lo} = {r_hi, r_lo} + w_prod;
            OP_MSUB: {w_res_hi, w_res_lo} = {r_hi, r_lo} - w_prod;
`endif
            default: w_res_hi = r_hi;
        endcase
    end

    // NOTE: operand latches carry no reset; they are only read after an accept has loaded them.
    always_ff @(posedge clk) begin
        if (w_accept && w_long) begin
            r_op <= op_e'(op);
            r_a  <= a;
            r_b  <= b;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_cnt  <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_busy) begin
                if (flush) begin
                    r_busy <= 1'b0;
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                        r_hi   <= w_res_hi;
                        r_lo   <= w_res_lo;
                    end
                end
            end else if (w_accept) begin
                if (w_long) begin
                    r_busy <= 1'b1;
                    r_cnt  <= w_load;
                end else if (op_e'(op) == OP_MTHI) begin
                    r_hi <= a;
                end else if (op_e'(op) == OP_MTLO) begin
                    r_lo <= a;
                end
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_pipe.sv
// Directed-vector bench for mdu_pipe: a table of single operations plus
// hand-written flush, stall, reset and multiply-accumulate sequences.
module tb_mdu_pipe;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    mdu_pipe dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        step();
        start = 1'b0;
    endtask

    // Counts edges until done, and busy samples from the current point; bounded at 40 cycles.
    task automatic wait_done(input string name, input int exp_lat);
        int lat = 0;
        int busy_cnt = 0;
        if (busy) busy_cnt++;
        while (!done && lat < 40) begin
            step();
            lat++;
            if (busy) busy_cnt++;
        end
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        check({name, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
    endtask

    task automatic watch_no_done(input string name, input int cycles);
        int pulses = 0;
        for (int k = 0; k < cycles; k++) begin
            step();
            if (done) pulses++;
        end
        check({name, "_no_done"}, 64'(pulses), 64'd0);
    endtask

    initial begin
        vecs[0] = '{3'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1] = '{3'd1, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 5};
        vecs[2] = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[4] = '{3'd3, 32'd7,        32'd0,        32'h00000000, 32'h80000000, 10};
        vecs[5] = '{3'd3, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10};
        vecs[6] = '{3'd4, 32'h00001234, 32'd0,        32'h00001234, 32'h0000000E, 0};
        vecs[7] = '{3'd5, 32'hAAAA5555, 32'd0,        32'h00001234, 32'hAAAA5555, 0};
        vecs[8] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
        vecs[9] = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};

        reset = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op    = 3'd0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);

        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            if (vecs[i].lat == 0) begin
                check($sformatf("vec%0d_busy", i), 64'(busy), 64'd0);
                check($sformatf("vec%0d_done", i), 64'(done), 64'd0);
            end else begin
                wait_done($sformatf("vec%0d", i), vecs[i].lat);
            end
            check($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].exp_hi));
            check($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].exp_lo));
            step();
            check($sformatf("vec%0d_done_after", i), 64'(done), 64'd0);
            check($sformatf("vec%0d_busy_after", i), 64'(busy), 64'd0);
        end

        // Flush mid-divide: result discarded, prior HI/LO retained.
        issue(3'd4, 32'h00001234, 32'd0);
        issue(3'd3, 32'd100, 32'd7);
        repeat (3) step();
        check("flush_mid_busy_before", 64'(busy), 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_mid_busy", 64'(busy), 64'd0);
        check("flush_mid_hi", 64'(hi), 64'h1234);
        check("flush_mid_lo", 64'(lo), 64'hFFFFFFFD);
        watch_no_done("flush_mid", 15);
        check("flush_mid_hi_late", 64'(hi), 64'h1234);

        // Flush on the completion edge: cancel wins.
        issue(3'd3, 32'd100, 32'd7);
        repeat (9) step();
        check("flush_last_busy_before", 64'(busy), 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_last_busy", 64'(busy), 64'd0);
        check("flush_last_done", 64'(done), 64'd0);
        check("flush_last_hi", 64'(hi), 64'h1234);
        check("flush_last_lo", 64'(lo), 64'hFFFFFFFD);

        // Flush while idle, and start together with flush.
        flush = 1'b1;
        step();
        check("flush_idle_busy", 64'(busy), 64'd0);
        issue(3'd4, 32'h0000DEAD, 32'd0);
        check("start_flush_mthi_hi", 64'(hi), 64'h1234);
        issue(3'd0, 32'd3, 32'd4);
        flush = 1'b0;
        check("start_flush_mult_busy", 64'(busy), 64'd0);
        watch_no_done("start_flush_mult", 8);

        // Start while busy is ignored.
        issue(3'd0, 32'd3, 32'd4);
        step();
        issue(3'd5, 32'h00009999, 32'd0);
        check("start_busy_lo_held", 64'(lo), 64'hFFFFFFFD);
        wait_done("start_busy", 3);
        check("start_busy_hi", 64'(hi), 64'd0);
        check("start_busy_lo", 64'(lo), 64'd12);

        // Reset in the middle of a multiply.
        issue(3'd0, 32'd5, 32'd6);
        step();
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("reset_mid_hi", 64'(hi), 64'd0);
        check("reset_mid_lo", 64'(lo), 64'd0);
        check("reset_mid_busy", 64'(busy), 64'd0);
        check("reset_mid_done", 64'(done), 64'd0);
        watch_no_done("reset_mid", 10);
        check("reset_mid_lo_late", 64'(lo), 64'd0);

        // Multiply-accumulate, or its absence.
        issue(3'd5, 32'd10, 32'd0);
        issue(3'd6, 32'd3, 32'd4);
`ifdef MDU_MADD_EN
        wait_done("madd", 5);
        check("madd_hi", 64'(hi), 64'd0);
        check("madd_lo", 64'(lo), 64'd22);
        step();
        issue(3'd7, 32'hFFFFFFFF, 32'd30);
        wait_done("msub", 5);
        check("msub_hi", 64'(hi), 64'd0);
        check("msub_lo", 64'(lo), 64'd52);
`else
        check("madd_off_busy", 64'(busy), 64'd0);
        watch_no_done("madd_off", 8);
        check("madd_off_lo", 64'(lo), 64'd10);
        check("madd_off_hi", 64'(hi), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
